secded_mem: RTL and testbench

- Parametrised single-error-correct / double-error-detect (SECDED) Hamming memory. It is the successor to the 12-bit SEC memory.
- Stores raw codewords of any data width in a register-array memory. On each read it returns the corrected codeword, the extracted data, error flags, the error position and saturating error counters.
- Sits between the codeword producer (encoder or error-injection path) and the consumers in the memory subsystem.

---
 rtl/secded_mem_if.sv | 67 ++++++
 rtl/secded_mem.sv | 212 +++++++++++++++++++++
 tb/tb_secded_mem.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/secded_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : secded_mem_if
// Description : Access bus between a codeword producer (master) and the
//               SECDED memory (slave). Carries the request (en/mode/addr/
//               data_in) and the registered read response (corrected
//               codeword, extracted data, error flags, error position and
//               saturating error counters).
//               Ports (master view):
//                 en       out 1       access request this cycle
//                 mode     out 1       1 = write, 0 = read
//                 addr     out ADDR_W  word address
//                 data_in  out CW      raw codeword to store
//                 data_out in  CW      corrected codeword
//                 data_o   in  DATA_W  data extracted from data_out
//                 valid    in  1       read result pulse
//                 sec_err  in  1       single error corrected
//                 ded_err  in  1       uncorrectable error
//                 err_pos  in  P       corrected bit position
//                 sec_cnt  in  CNT_W   saturating single-error count
//                 ded_cnt  in  CNT_W   saturating double-error count
// Revision    : 1.0 - initial release
// ============================================================================
interface secded_mem_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
);

  // Smallest P with 2^P >= DATA_W + P + 1.
  function automatic int calc_p(input int dw);
    int p;
    p = 1;
    for (int k = 0; k < 8; k++) begin
      if ((1 << p) < dw + p + 1) p = p + 1;
    end
    return p;
  endfunction

  localparam int P  = calc_p(DATA_W);
  localparam int CW = DATA_W + P + 1;

  logic              en;
  logic              mode;
  logic [ADDR_W-1:0] addr;
  logic [CW-1:0]     data_in;
  logic [CW-1:0]     data_out;
  logic [DATA_W-1:0] data_o;
  logic              valid;
  logic              sec_err;
  logic              ded_err;
  logic [P-1:0]      err_pos;
  logic [CNT_W-1:0]  sec_cnt;
  logic [CNT_W-1:0]  ded_cnt;

  modport master (
    output en, mode, addr, data_in,
    input  data_out, data_o, valid, sec_err, ded_err, err_pos, sec_cnt, ded_cnt
  );

  modport slave (
    input  en, mode, addr, data_in,
    output data_out, data_o, valid, sec_err, ded_err, err_pos, sec_cnt, ded_cnt
  );

endinterface
`default_nettype wire

// File: rtl/secded_mem.sv
`default_nettype none
// ============================================================================
// Module      : secded_mem
// Description : Parametrised SECDED Hamming memory. Stores raw codewords in a
//               register array; every read is decoded one cycle after the
//               request and returns the corrected codeword, extracted data,
//               sec/ded flags, the corrected bit position and saturating
//               error counters.
//               Codeword layout: bit 0 = overall even parity, bits 2^k =
//               Hamming parity, remaining positions = data in ascending order
//               (position 3 -> data_o[0]).
//               Ports:
//                 clk     in  1        clock, rising edge
//                 rst     in  1        synchronous active-high reset
//                 mem_if  slave        request/response bus (secded_mem_if)
//               Optional feature (macro SECDED_WRITEBACK_EN): a read that
//               corrects a single error writes the corrected codeword back
//               to the read address one edge after the result (scrubbing),
//               unless an external write occupies either of those edges.
// Revision    : 1.0 - initial release
// ============================================================================
module secded_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input wire logic     clk,
  input wire logic     rst,
  secded_mem_if.slave  mem_if
);

  // Smallest P with 2^P >= DATA_W + P + 1.
  function automatic int calc_p(input int dw);
    int p;
    p = 1;
    for (int k = 0; k < 8; k++) begin
      if ((1 << p) < dw + p + 1) p = p + 1;
    end
    return p;
  endfunction

  // Codeword position of the k-th data bit: k-th index >= 3 that is not a
  // power of two.
  function automatic int data_pos(input int k);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int i = 3; i < 128; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (cnt == k) pos = i;
        cnt = cnt + 1;
      end
    end
    return pos;
  endfunction

  localparam int P     = calc_p(DATA_W);
  localparam int CW    = DATA_W + P + 1;
  localparam int DEPTH = 1 << ADDR_W;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CW-1:0]     mem_q [DEPTH];

  // Read request captured at edge N, decoded from memory at edge N+1.
  logic              rd_pend_q;
  logic [ADDR_W-1:0] raddr_q;

  logic [CW-1:0]     dout_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              sec_q;
  logic              ded_q;
  logic [P-1:0]      pos_q;
  logic [CNT_W-1:0]  sec_cnt_q;
  logic [CNT_W-1:0]  ded_cnt_q;

`ifdef SECDED_WRITEBACK_EN
  logic              wb_pend_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [CW-1:0]     wb_data_q;
`endif

  // --------------------------------------------------------------------------
  // Decode of the word addressed by the pending read
  // --------------------------------------------------------------------------
  logic [CW-1:0]     word_d;
  logic [P-1:0]      syn_d;
  logic              par_d;
  logic [CW-1:0]     dout_d;
  logic [DATA_W-1:0] data_d;
  logic              sec_d;
  logic              ded_d;
  logic [P-1:0]      pos_d;
  logic              wr_d;

  assign wr_d = mem_if.en && mem_if.mode;

  always_comb begin
    word_d = mem_q[raddr_q];

    // Syndrome = XOR of the indices of all set bits above position 0.
    syn_d = '0;
    for (int i = 1; i < CW; i++) begin
      if (word_d[i]) syn_d = syn_d ^ P'(i);
    end
    par_d = ^word_d;

    dout_d = word_d;
    sec_d  = 1'b0;
    ded_d  = 1'b0;
    pos_d  = '0;

    if (par_d) begin
      // Odd overall parity: a single flip, unless the syndrome points past
      // the end of the codeword (only possible when CW < 2^P).
      if (int'(syn_d) <= CW - 1) begin
        sec_d = 1'b1;
        pos_d = syn_d;
        for (int i = 0; i < CW; i++) begin
          if (P'(i) == syn_d) dout_d[i] = ~word_d[i];
        end
      end else begin
        ded_d = 1'b1;
      end
    end else if (syn_d != '0) begin
      ded_d = 1'b1;
    end
  end

  for (genvar k = 0; k < DATA_W; k++) begin : g_extract
    assign data_d[k] = dout_d[data_pos(k)];
  end

  // --------------------------------------------------------------------------
  // Sequential: memory, read pipeline, counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_pend_q <= 1'b0;
      raddr_q   <= '0;
      dout_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sec_q     <= 1'b0;
      ded_q     <= 1'b0;
      pos_q     <= '0;
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
`ifdef SECDED_WRITEBACK_EN
      wb_pend_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
`endif
    end else begin
      rd_pend_q <= mem_if.en && !mem_if.mode;
      raddr_q   <= mem_if.addr;

      valid_q <= rd_pend_q;
      sec_q   <= rd_pend_q && sec_d;
      ded_q   <= rd_pend_q && ded_d;

      // Data, data_o and err_pos hold between reads.
      if (rd_pend_q) begin
        dout_q <= dout_d;
        data_q <= data_d;
        pos_q  <= pos_d;
      end

      if (rd_pend_q && sec_d && (sec_cnt_q != {CNT_W{1'b1}})) begin
        sec_cnt_q <= sec_cnt_q + CNT_W'(1);
      end
      if (rd_pend_q && ded_d && (ded_cnt_q != {CNT_W{1'b1}})) begin
        ded_cnt_q <= ded_cnt_q + CNT_W'(1);
      end

      // External writes always win over a pending scrub.
      if (wr_d) begin
        mem_q[mem_if.addr] <= mem_if.data_in;
      end
`ifdef SECDED_WRITEBACK_EN
      else if (wb_pend_q) begin
        mem_q[wb_addr_q] <= wb_data_q;
      end

      // A write on the result edge also cancels the scrub.
      wb_pend_q <= rd_pend_q && sec_d && !wr_d;
      wb_addr_q <= raddr_q;
      wb_data_q <= dout_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_if.data_out = dout_q;
  assign mem_if.data_o   = data_q;
  assign mem_if.valid    = valid_q;
  assign mem_if.sec_err  = sec_q;
  assign mem_if.ded_err  = ded_q;
  assign mem_if.err_pos  = pos_q;
  assign mem_if.sec_cnt  = sec_cnt_q;
  assign mem_if.ded_cnt  = ded_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_secded_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_secded_mem
// Description : Self-checking bench for secded_mem. Directed scenarios plus a
//               randomized run checked against a behavioural model that
//               decodes by brute force (try every single-bit flip and test
//               whether the result is a legal codeword).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_secded_mem;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 8;
  localparam int P      = 4;
  localparam int CW     = 13;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  secded_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  secded_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .mem_if (bus)
  );

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  logic [CW-1:0]     m_mem [DEPTH];
  bit                m_rd_pend;
  int                m_rd_addr;
  bit                m_wb_pend;
  int                m_wb_addr;
  logic [CW-1:0]     m_wb_data;
  bit                m_valid, m_sec, m_ded;
  logic [CW-1:0]     m_dout;
  logic [DATA_W-1:0] m_do;
  logic [P-1:0]      m_pos;
  int                m_sec_cnt, m_ded_cnt;

  function automatic bit is_pow2(input int i);
    return (i & (i - 1)) == 0;
  endfunction

  // Legal codeword: even overall parity and even parity for every Hamming group.
  function automatic bit is_codeword(input logic [CW-1:0] w);
    bit acc;
    if (^w) return 1'b0;
    for (int k = 0; k < P; k++) begin
      acc = 1'b0;
      for (int i = 1; i < CW; i++) if (((i >> k) & 1) == 1) acc ^= w[i];
      if (acc) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [CW-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CW-1:0] w;
    int n;
    bit acc;
    w = '0;
    n = 0;
    for (int i = 1; i < CW; i++) begin
      if (!is_pow2(i)) begin
        w[i] = d[n];
        n++;
      end
    end
    for (int k = 0; k < P; k++) begin
      acc = 1'b0;
      for (int i = 1; i < CW; i++) if (((i >> k) & 1) == 1) acc ^= w[i];
      w[1 << k] = acc;
    end
    w[0] = ^w;
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CW-1:0] w);
    logic [DATA_W-1:0] d;
    int n;
    d = '0;
    n = 0;
    for (int i = 1; i < CW; i++) begin
      if (!is_pow2(i)) begin
        d[n] = w[i];
        n++;
      end
    end
    return d;
  endfunction

  // kind: 0 clean, 1 single corrected, 2 uncorrectable.
  function automatic void classify(input logic [CW-1:0] w, output int kind,
                                   output logic [CW-1:0] fixed, output int pos);
    logic [CW-1:0] t;
    kind  = 2;
    fixed = w;
    pos   = 0;
    if (is_codeword(w)) begin
      kind = 0;
      return;
    end
    for (int j = 0; j < CW; j++) begin
      t = w;
      t[j] = ~t[j];
      if (is_codeword(t)) begin
        kind  = 1;
        fixed = t;
        pos   = j;
        return;
      end
    end
  endfunction

  function automatic void model_edge(input bit r, input bit e, input bit m,
                                     input int a, input logic [CW-1:0] d);
    int kind, pos;
    logic [CW-1:0] fixed;
    bit new_sec;
    if (r) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_rd_pend = 0; m_rd_addr = 0; m_wb_pend = 0;
      m_valid = 0; m_sec = 0; m_ded = 0;
      m_dout = '0; m_do = '0; m_pos = '0;
      m_sec_cnt = 0; m_ded_cnt = 0;
      return;
    end
    m_valid = 0; m_sec = 0; m_ded = 0;
    if (m_rd_pend) begin
      classify(m_mem[m_rd_addr], kind, fixed, pos);
      m_valid = 1;
      m_sec   = (kind == 1);
      m_ded   = (kind == 2);
      m_dout  = fixed;
      m_do    = extract(fixed);
      m_pos   = P'(pos);
      if (m_sec && m_sec_cnt < 255) m_sec_cnt++;
      if (m_ded && m_ded_cnt < 255) m_ded_cnt++;
    end
    new_sec = m_sec;
    if (e && m) m_mem[a] = d;
`ifdef SECDED_WRITEBACK_EN
    else if (m_wb_pend) m_mem[m_wb_addr] = m_wb_data;
`endif
    m_wb_pend = new_sec && !(e && m);
    m_wb_addr = m_rd_addr;
    m_wb_data = m_dout;
    m_rd_pend = e && !m;
    m_rd_addr = a;
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus primitives
  // --------------------------------------------------------------------------
  task automatic step(input bit r, input bit e, input bit m, input int a,
                      input logic [CW-1:0] d);
    rst         = r;
    bus.en      = e;
    bus.mode    = m;
    bus.addr    = ADDR_W'(a);
    bus.data_in = d;
    @(posedge clk);
    #1;
    model_edge(r, e, m, a, d);
  endtask

  task automatic do_write(input int a, input logic [CW-1:0] d);
    step(0, 1, 1, a, d);
  endtask

  task automatic do_read(input int a);
    step(0, 1, 0, a, '0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, '0);
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    step(1, 0, 0, 0, '0);
    step(1, 1, 0, 7, '0);
    n_tests++;
    if ({bus.valid, bus.sec_err, bus.ded_err} !== 3'b000 || bus.data_out !== 13'h0000 ||
        bus.sec_cnt !== 8'h00 || bus.ded_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state flags=%b dout=%h cnt=%h/%h exp flags=000 dout=0000 cnt=00/00",
               {bus.valid, bus.sec_err, bus.ded_err}, bus.data_out, bus.sec_cnt, bus.ded_cnt);
    end
    do_read(7);
    n_tests++;
    if (bus.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_read_latency valid=%b exp=0 on request edge", bus.valid);
    end
    idle();
    n_tests++;
    if ({bus.valid, bus.sec_err, bus.ded_err} !== 3'b100 || bus.data_out !== 13'h0000 ||
        bus.data_o !== 8'h00 || bus.sec_cnt !== 8'h00 || bus.ded_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_read7 flags=%b dout=%h do=%h cnt=%h/%h exp flags=100 dout=0000 do=00 cnt=00/00",
               {bus.valid, bus.sec_err, bus.ded_err}, bus.data_out, bus.data_o, bus.sec_cnt, bus.ded_cnt);
    end
    idle();
    n_tests++;
    if (bus.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_pulse valid=%b exp=0", bus.valid);
    end
  endtask

  task automatic test_write_read();
    do_write(2, 13'h1EEE);
    do_read(2);
    idle();
    n_tests++;
    if ({bus.valid, bus.sec_err, bus.ded_err} !== 3'b100 || bus.data_out !== 13'h1EEE ||
        bus.data_o !== 8'hFF) begin
      n_fail++;
      $display("FAIL clean_read flags=%b dout=%h do=%h exp flags=100 dout=1eee do=ff",
               {bus.valid, bus.sec_err, bus.ded_err}, bus.data_out, bus.data_o);
    end
    idle();
    n_tests++;
    if (bus.valid !== 1'b0 || bus.data_out !== 13'h1EEE || bus.data_o !== 8'hFF) begin
      n_fail++;
      $display("FAIL output_hold valid=%b dout=%h do=%h exp valid=0 dout=1eee do=ff",
               bus.valid, bus.data_out, bus.data_o);
    end
  endtask

  task automatic test_sec();
    do_write(3, 13'h0020);
    do_read(3);
    idle();
    n_tests++;
    if ({bus.valid, bus.sec_err, bus.ded_err} !== 3'b110 || bus.data_out !== 13'h0000 ||
        bus.err_pos !== 4'd5 || bus.sec_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL sec_bit5 flags=%b dout=%h pos=%0d cnt=%0d exp flags=110 dout=0000 pos=5 cnt=1",
               {bus.valid, bus.sec_err, bus.ded_err}, bus.data_out, bus.err_pos, bus.sec_cnt);
    end
    do_write(3, 13'h0001);
    do_read(3);
    idle();
    n_tests++;
    if ({bus.valid, bus.sec_err, bus.ded_err} !== 3'b110 || bus.data_out !== 13'h0000 ||
        bus.err_pos !== 4'd0 || bus.sec_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL sec_bit0 flags=%b dout=%h pos=%0d cnt=%0d exp flags=110 dout=0000 pos=0 cnt=2",
               {bus.valid, bus.sec_err, bus.ded_err}, bus.data_out, bus.err_pos, bus.sec_cnt);
    end
  endtask

  task automatic test_ded();
    do_write(3, 13'h0028);
    do_read(3);
    idle();
    n_tests++;
    if ({bus.valid, bus.sec_err, bus.ded_err} !== 3'b101 || bus.data_out !== 13'h0028 ||
        bus.data_o !== 8'h03 || bus.err_pos !== 4'd0 || bus.ded_cnt !== 8'd1 ||
        bus.sec_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL ded flags=%b dout=%h do=%h pos=%0d cnt=%0d/%0d exp flags=101 dout=0028 do=03 pos=0 cnt=2/1",
               {bus.valid, bus.sec_err, bus.ded_err}, bus.data_out, bus.data_o, bus.err_pos,
               bus.sec_cnt, bus.ded_cnt);
    end
  endtask

  task automatic test_saturation();
    // Rewriting before every read keeps the word erroneous even when scrubbing.
    for (int i = 0; i < 300; i++) begin
      do_write(3, 13'h0020);
      do_read(3);
    end
    idle();
    n_tests++;
    if (bus.sec_cnt !== 8'hFF || bus.ded_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL sec_cnt_saturate cnt=%h/%h exp ff/01", bus.sec_cnt, bus.ded_cnt);
    end
    // Reset with a read in flight: the read is discarded.
    do_read(3);
    step(1, 0, 0, 0, '0);
    n_tests++;
    if (bus.valid !== 1'b0 || bus.sec_err !== 1'b0 || bus.sec_cnt !== 8'h00 ||
        bus.ded_cnt !== 8'h00 || bus.data_out !== 13'h0000) begin
      n_fail++;
      $display("FAIL midrun_reset valid=%b sec=%b cnt=%h/%h dout=%h exp 0 0 00/00 0000",
               bus.valid, bus.sec_err, bus.sec_cnt, bus.ded_cnt, bus.data_out);
    end
    idle();
    n_tests++;
    if (bus.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_discard valid=%b exp=0", bus.valid);
    end
    do_read(3);
    do_read(2);
    n_tests++;
    if ({bus.valid, bus.sec_err, bus.ded_err} !== 3'b100 || bus.data_out !== 13'h0000) begin
      n_fail++;
      $display("FAIL post_reset_addr3 flags=%b dout=%h exp flags=100 dout=0000",
               {bus.valid, bus.sec_err, bus.ded_err}, bus.data_out);
    end
    idle();
    n_tests++;
    if ({bus.valid, bus.sec_err, bus.ded_err} !== 3'b100 || bus.data_out !== 13'h0000) begin
      n_fail++;
      $display("FAIL post_reset_addr2 flags=%b dout=%h exp flags=100 dout=0000",
               {bus.valid, bus.sec_err, bus.ded_err}, bus.data_out);
    end
  endtask

  task automatic test_scrub();
    bit exp_sec;
`ifdef SECDED_WRITEBACK_EN
    exp_sec = 1'b0;
`else
    exp_sec = 1'b1;
`endif
    do_write(3, 13'h0020);
    do_read(3);
    idle();
    n_tests++;
    if (bus.sec_err !== 1'b1) begin
      n_fail++;
      $display("FAIL scrub_first sec=%b exp=1", bus.sec_err);
    end
    idle();
    do_read(3);
    idle();
    n_tests++;
    if (bus.valid !== 1'b1 || bus.sec_err !== exp_sec || bus.data_out !== 13'h0000) begin
      n_fail++;
      $display("FAIL scrub_second valid=%b sec=%b dout=%h exp valid=1 sec=%b dout=0000",
               bus.valid, bus.sec_err, bus.data_out, exp_sec);
    end
  endtask

  task automatic test_random();
    logic [CW-1:0] d;
    int j, j2;
    bit e, m;
    for (int c = 0; c < 600; c++) begin
      d = encode(DATA_W'($urandom));
      case ($urandom_range(3))
        0: ;
        1: begin
          j = $urandom_range(CW - 1);
          d[j] = ~d[j];
        end
        2: begin
          j  = $urandom_range(CW - 1);
          j2 = (j + 1 + $urandom_range(CW - 2)) % CW;
          d[j]  = ~d[j];
          d[j2] = ~d[j2];
        end
        default: d = CW'($urandom);
      endcase
      e = ($urandom_range(7) != 0);
      m = ($urandom_range(2) == 0);
      // Few addresses so reads hit recently written and scrubbed words.
      step(0, e, m, $urandom_range(5), d);
      n_tests++;
      if ({bus.valid, bus.sec_err, bus.ded_err} !== {m_valid, m_sec, m_ded} ||
          bus.data_out !== m_dout || bus.data_o !== m_do || bus.err_pos !== m_pos ||
          bus.sec_cnt !== CNT_W'(m_sec_cnt) || bus.ded_cnt !== CNT_W'(m_ded_cnt)) begin
        n_fail++;
        $display("FAIL random cyc=%0d flags=%b/%b dout=%h/%h do=%h/%h pos=%0d/%0d cnt=%0d,%0d/%0d,%0d (got/exp)",
                 c, {bus.valid, bus.sec_err, bus.ded_err}, {m_valid, m_sec, m_ded},
                 bus.data_out, m_dout, bus.data_o, m_do, bus.err_pos, m_pos,
                 bus.sec_cnt, bus.ded_cnt, m_sec_cnt, m_ded_cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_write(0, encode(8'hA5));
    do_write(1, encode(8'h3C) ^ 13'h0400);
    do_read(0);
    do_read(1);
    n_tests++;
    if ({bus.valid, bus.sec_err} !== 2'b10 || bus.data_o !== 8'hA5) begin
      n_fail++;
      $display("FAIL b2b_first flags=%b do=%h exp flags=10 do=a5", {bus.valid, bus.sec_err}, bus.data_o);
    end
    idle();
    n_tests++;
    if ({bus.valid, bus.sec_err} !== 2'b11 || bus.data_o !== 8'h3C || bus.err_pos !== 4'd10) begin
      n_fail++;
      $display("FAIL b2b_second flags=%b do=%h pos=%0d exp flags=11 do=3c pos=10",
               {bus.valid, bus.sec_err}, bus.data_o, bus.err_pos);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.mode    = 1'b0;
    bus.addr    = '0;
    bus.data_in = '0;
    test_reset();
    test_write_read();
    test_sec();
    test_ded();
    test_saturation();
    test_scrub();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
